// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the control path and the ALU execute unit.
// The master drives operands and the start strobe; the slave returns results and status.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_op, funct, shamt, operand_a, operand_b,
        input  result, zero, hi, lo, busy, done
    );

    modport slave (
        input  start, alu_op, funct, shamt, operand_a, operand_b,
        output result, zero, hi, lo, busy, done
    );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS-style execute unit: single-cycle ALU ops plus iterative unsigned
// shift-add multiply and restoring divide into hi/lo.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_exec_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    typedef enum logic [3:0] {
        OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_NOR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_DIV, OP_MFHI, OP_MFLO
    } op_t;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_t             state;
    op_t                op;
    logic [SHW-1:0]     count;
    logic [WIDTH-1:0]   result_q, hi_q, lo_q;
    logic               zero_q, busy_q, done_q;
    logic [WIDTH-1:0]   opnd_q, rem_q, quo_q;
    logic [2*WIDTH:0]   prod_q;
    logic [WIDTH-1:0]   alu_out;
    logic [2*WIDTH:0]   prod_add, prod_next;
    logic [WIDTH:0]     rem_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next, quo_next;

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    always_comb begin
        op = OP_AND;
        case (bus.alu_op)
            2'b11: op = OP_AND;
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            default: begin
                case (bus.funct)
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b000000: op = OP_SLL;
                    6'b000010: op = OP_SRL;
                    6'b000011: op = OP_SRA;
                    6'b011000: op = OP_MULT;
                    6'b011010: op = OP_DIV;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    default:   op = OP_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_out = bus.operand_a & bus.operand_b;
        case (op)
            OP_OR:   alu_out = bus.operand_a | bus.operand_b;
            OP_ADD:  alu_out = bus.operand_a + bus.operand_b;
            OP_SUB:  alu_out = bus.operand_a - bus.operand_b;
            OP_XOR:  alu_out = bus.operand_a ^ bus.operand_b;
            OP_NOR:  alu_out = ~(bus.operand_a | bus.operand_b);
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}},
                                ($signed(bus.operand_a) < $signed(bus.operand_b))};
            OP_SLL:  alu_out = bus.operand_b << bus.shamt;
            OP_SRL:  alu_out = bus.operand_b >> bus.shamt;
            OP_SRA:  alu_out = $signed(bus.operand_b) >>> bus.shamt;
            OP_MFHI: alu_out = hi_q;
            OP_MFLO: alu_out = lo_q;
            default: ;
        endcase
    end

    // Multiply: prod_q holds {partial sum, remaining multiplier bits}, shifted right each step.
    always_comb begin
        prod_add = prod_q;
        if (prod_q[0]) begin
            prod_add[2*WIDTH:WIDTH] = prod_q[2*WIDTH:WIDTH] + {1'b0, opnd_q};
        end
        prod_next = prod_add >> 1;
    end

    // Divide: shift the next dividend bit into the remainder and subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = (rem_shift >= {1'b0, opnd_q});
        rem_next  = div_ge ? WIDTH'(rem_shift - {1'b0, opnd_q}) : rem_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            opnd_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            prod_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (op == OP_MULT) begin
                            opnd_q <= bus.operand_a;
                            prod_q <= {{(WIDTH+1){1'b0}}, bus.operand_b};
                            count  <= '0;
                            busy_q <= 1'b1;
                            state  <= MUL;
                        end else if (op == OP_DIV) begin
                            // Divide by zero finishes immediately with a saturated quotient.
                            if (bus.operand_b == '0) begin
                                lo_q   <= '1;
                                hi_q   <= bus.operand_a;
                                done_q <= 1'b1;
                            end else begin
                                opnd_q <= bus.operand_b;
                                rem_q  <= '0;
                                quo_q  <= bus.operand_a;
                                count  <= '0;
                                busy_q <= 1'b1;
                                state  <= DIV;
                            end
                        end else begin
                            result_q <= alu_out;
                            zero_q   <= (alu_out == '0);
                            done_q   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod_q <= prod_next;
                    if (count == LAST) begin
                        hi_q   <= prod_next[2*WIDTH-1:WIDTH];
                        lo_q   <= prod_next[WIDTH-1:0];
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        count  <= '0;
                        state  <= IDLE;
                    end else begin
                        count <= count + SHW'(1);
                    end
                end
                DIV: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (count == LAST) begin
                        hi_q   <= rem_next;
                        lo_q   <= quo_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        count  <= '0;
                        state  <= IDLE;
                    end else begin
                        count <= count + SHW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit, checked every cycle against
// an arithmetic model that tracks result, hi/lo and the multi-cycle latency.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum {R_AND, R_OR, R_ADD, R_SUB, R_XOR, R_NOR, R_SLT,
                  R_SLL, R_SRL, R_SRA, R_MULT, R_DIV, R_MFHI, R_MFLO} ref_op_t;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] mResult = '0;
    logic [31:0] mHi     = '0;
    logic [31:0] mLo     = '0;
    logic        mBusy   = 1'b0;
    logic        mDone   = 1'b0;
    int          mRemaining = 0;
    logic [31:0] mPendHi = '0;
    logic [31:0] mPendLo = '0;
    logic [63:0] mProd;
    ref_op_t     mOp;

    logic [7:0] codes [0:11] = '{8'hA4, 8'hA5, 8'hA0, 8'hA2, 8'hA6, 8'hA7,
                                 8'hAA, 8'h80, 8'h82, 8'h83, 8'h90, 8'h92};

    function automatic ref_op_t refDecode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b11) return R_AND;
        if (op == 2'b00) return R_ADD;
        if (op == 2'b01) return R_SUB;
        case (f)
            6'b100101: return R_OR;
            6'b100000: return R_ADD;
            6'b100010: return R_SUB;
            6'b100110: return R_XOR;
            6'b100111: return R_NOR;
            6'b101010: return R_SLT;
            6'b000000: return R_SLL;
            6'b000010: return R_SRL;
            6'b000011: return R_SRA;
            6'b011000: return R_MULT;
            6'b011010: return R_DIV;
            6'b010000: return R_MFHI;
            6'b010010: return R_MFLO;
            default:   return R_AND;
        endcase
    endfunction

    function automatic logic [31:0] refAlu(input ref_op_t o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh,
                                           input logic [31:0] h, input logic [31:0] l);
        logic [63:0] t;
        logic [63:0] pow2;
        pow2 = 64'd1 << sh;
        case (o)
            R_OR:   return a | b;
            R_ADD:  begin t = {32'd0, a} + {32'd0, b};               return t[31:0]; end
            R_SUB:  begin t = {32'd1, a} - {32'd0, b};               return t[31:0]; end
            R_XOR:  return a ^ b;
            R_NOR:  return ~(a | b);
            R_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            R_SLL:  begin t = {32'd0, b} * pow2;                     return t[31:0]; end
            R_SRL:  begin t = {32'd0, b} / pow2;                     return t[31:0]; end
            R_SRA:  begin t = {{32{b[31]}}, b} >> sh;                return t[31:0]; end
            R_MFHI: return h;
            R_MFLO: return l;
            default: return a & b;
        endcase
    endfunction

    // Reference model: latency is a countdown, values come from plain arithmetic.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mResult = '0; mHi = '0; mLo = '0;
            mBusy = 1'b0; mDone = 1'b0; mRemaining = 0;
        end else begin
            mDone = 1'b0;
            if (mRemaining > 0) begin
                mRemaining = mRemaining - 1;
                if (mRemaining == 0) begin
                    mHi = mPendHi; mLo = mPendLo; mBusy = 1'b0; mDone = 1'b1;
                end
            end else if (bus.start) begin
                mOp = refDecode(bus.alu_op, bus.funct);
                if (mOp == R_MULT) begin
                    mProd      = {32'd0, bus.operand_a} * {32'd0, bus.operand_b};
                    mPendHi    = mProd[63:32];
                    mPendLo    = mProd[31:0];
                    mRemaining = WIDTH;
                    mBusy      = 1'b1;
                end else if (mOp == R_DIV) begin
                    if (bus.operand_b == 32'd0) begin
                        mLo = 32'hFFFF_FFFF; mHi = bus.operand_a; mDone = 1'b1;
                    end else begin
                        mPendLo    = bus.operand_a / bus.operand_b;
                        mPendHi    = bus.operand_a % bus.operand_b;
                        mRemaining = WIDTH;
                        mBusy      = 1'b1;
                    end
                end else begin
                    mResult = refAlu(mOp, bus.operand_a, bus.operand_b, bus.shamt, mHi, mLo);
                    mDone   = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    initial forever begin
        @(negedge clk);
        checkOutput("cyc_result", bus.result, mResult);
        checkOutput("cyc_zero",   bus.zero,   mResult == 32'd0);
        checkOutput("cyc_hi",     bus.hi,     mHi);
        checkOutput("cyc_lo",     bus.lo,     mLo);
        checkOutput("cyc_busy",   bus.busy,   mBusy);
        checkOutput("cyc_done",   bus.done,   mDone);
    end

    task automatic driveInputs(input logic s, input logic [1:0] op, input logic [5:0] f,
                               input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        bus.start     = s;
        bus.alu_op    = op;
        bus.funct     = f;
        bus.shamt     = sh;
        bus.operand_a = a;
        bus.operand_b = b;
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] op, input logic [5:0] f,
                                 input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        driveInputs(s, op, f, sh, a, b);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 2'($urandom), 6'($urandom), 5'($urandom), $urandom, $urandom);
    endtask

    task automatic waitForDone(output int busyCycles, output logic seen);
        busyCycles = 0;
        seen       = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            idleCycle();
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busyCycles++;
        end
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] randCode();
        int k;
        k = $urandom_range(0, 17);
        if (k < 12) return codes[k];
        case (k)
            12: return {2'b00, 6'($urandom)};
            13: return {2'b01, 6'($urandom)};
            14: return {2'b11, 6'($urandom)};
            15: return {2'b10, 6'($urandom)};
            16: return 8'h98;
            default: return 8'h9A;
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int          busyCycles;
        int          doneCount;
        logic        seen;
        logic [7:0]  code;

        driveInputs(1'b0, 2'b00, 6'd0, 5'd0, 32'd0, 32'd0);
        #1 reset = 1'b1;
        #2;
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_zero",   bus.zero,   1'b1);
        checkOutput("reset_hi",     bus.hi,     32'd0);
        checkOutput("reset_lo",     bus.lo,     32'd0);
        checkOutput("reset_busy",   bus.busy,   1'b0);
        checkOutput("reset_done",   bus.done,   1'b0);

        // First issue is presented together with reset release.
        @(negedge clk);
        driveInputs(1'b1, 2'b10, 6'b100010, 5'd0, 32'd5, 32'd7);
        reset = 1'b0;
        idleCycle();
        checkOutput("sub_result", bus.result, 32'hFFFF_FFFE);
        checkOutput("sub_zero",   bus.zero,   1'b0);
        checkOutput("sub_done",   bus.done,   1'b1);
        checkOutput("model_sub",  mResult,    32'hFFFF_FFFE);
        idleCycle();
        checkOutput("done_pulse_low", bus.done, 1'b0);

        applyStimulus(1'b1, 2'b10, 6'b000011, 5'd4, 32'd0, 32'h8000_0000);
        idleCycle();
        checkOutput("sra_result", bus.result, 32'hF800_0000);
        checkOutput("model_sra",  mResult,    32'hF800_0000);
        applyStimulus(1'b1, 2'b10, 6'b000010, 5'd4, 32'd0, 32'h8000_0000);
        idleCycle();
        checkOutput("srl_result", bus.result, 32'h0800_0000);
        applyStimulus(1'b1, 2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1);
        idleCycle();
        checkOutput("slt_result", bus.result, 32'd1);
        applyStimulus(1'b1, 2'b01, 6'b111111, 5'd0, 32'h1234, 32'h1234);
        idleCycle();
        checkOutput("sub_zero_result", bus.result, 32'd0);
        checkOutput("sub_zero_flag",   bus.zero,   1'b1);
        applyStimulus(1'b1, 2'b10, 6'b111111, 5'd0, 32'h0000_F0F0, 32'h0000_FF00);
        idleCycle();
        checkOutput("default_and", bus.result, 32'h0000_F000);

        applyStimulus(1'b1, 2'b10, 6'b011000, 5'd0, 32'hFFFF_FFFF, 32'd2);
        waitForDone(busyCycles, seen);
        checkOutput("mult_done_seen",   seen,       1'b1);
        checkOutput("mult_busy_cycles", busyCycles, 32);
        checkOutput("mult_hi",          bus.hi,     32'd1);
        checkOutput("mult_lo",          bus.lo,     32'hFFFF_FFFE);
        checkOutput("mult_result_kept", bus.result, 32'h0000_F000);
        applyStimulus(1'b1, 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0);
        idleCycle();
        checkOutput("mflo_result", bus.result, 32'hFFFF_FFFE);

        applyStimulus(1'b1, 2'b10, 6'b011010, 5'd0, 32'd100, 32'd7);
        waitForDone(busyCycles, seen);
        checkOutput("div_done_seen",   seen,       1'b1);
        checkOutput("div_busy_cycles", busyCycles, 32);
        checkOutput("div_lo",          bus.lo,     32'd14);
        checkOutput("div_hi",          bus.hi,     32'd2);
        checkOutput("model_div_lo",    mLo,        32'd14);
        applyStimulus(1'b1, 2'b10, 6'b011010, 5'd0, 32'd100, 32'd0);
        idleCycle();
        checkOutput("div0_done", bus.done, 1'b1);
        checkOutput("div0_busy", bus.busy, 1'b0);
        checkOutput("div0_lo",   bus.lo,   32'hFFFF_FFFF);
        checkOutput("div0_hi",   bus.hi,   32'd100);

        // Starts held high through a multiply; the one on the done cycle issues an ADD.
        applyStimulus(1'b1, 2'b10, 6'b011000, 5'd0, 32'd3, 32'd5);
        doneCount = 0;
        for (int i = 0; i <= 32; i++) begin
            applyStimulus(1'b1, 2'b10, 6'b100000, 5'd0, 32'd1, 32'd1);
            if (bus.done) doneCount++;
        end
        checkOutput("b2b_single_done", doneCount, 1);
        checkOutput("b2b_mult_lo",     bus.lo,    32'd15);
        idleCycle();
        checkOutput("b2b_add_done",   bus.done,   1'b1);
        checkOutput("b2b_add_result", bus.result, 32'd2);

        // Reset arriving mid-divide takes effect between clock edges.
        applyStimulus(1'b1, 2'b10, 6'b011010, 5'd0, 32'd1000, 32'd3);
        repeat (11) idleCycle();
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_busy", bus.busy, 1'b0);
        checkOutput("abort_hi",   bus.hi,   32'd0);
        checkOutput("abort_lo",   bus.lo,   32'd0);
        checkOutput("abort_done", bus.done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            idleCycle();
            if (bus.done) doneCount++;
        end
        checkOutput("abort_no_done", doneCount, 0);
        applyStimulus(1'b1, 2'b00, 6'($urandom), 5'd0, 32'd3, 32'd4);
        idleCycle();
        checkOutput("post_abort_add", bus.result, 32'd7);

        for (int i = 0; i < 600; i++) begin
            code = randCode();
            applyStimulus(1'($urandom_range(0, 1)), code[7:6], code[5:0],
                          5'($urandom), randOperand(), randOperand());
        end
        repeat (40) idleCycle();

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
